// File: rtl/mips_mem_pkg.sv
// Shared types and constants for the MEM-stage SRAM path.
package mips_mem_pkg;
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RD_LO = 3'd1,
    RD_HI = 3'd2,
    WR_LO = 3'd3,
    WR_HI = 3'd4,
    DONE  = 3'd5
  } sram_state_t;

  localparam logic [31:0] DATA_BASE = 32'd1024;
  localparam int          SRAM_AW   = 18;
  localparam int          SRAM_DW   = 16;
endpackage

// File: rtl/sram_controller_if.sv
// Mem_Stage <-> SRAM controller request/busy port.
interface sram_controller_if;
  logic        rd_en;
  logic        wr_en;
  logic [31:0] address;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        busy;

  modport master (output rd_en, wr_en, address, write_data, input read_data, busy);
  modport slave  (input rd_en, wr_en, address, write_data, output read_data, busy);
endinterface

// File: rtl/sram_controller.sv
// Splits 32-bit loads/stores into two 16-bit SRAM accesses (low half first)
// and raises busy to freeze the pipeline for the duration.
module sram_controller #(
  parameter int unsigned PHASE_CYCLES = 2,
  parameter logic [31:0] DATA_BASE    = mips_mem_pkg::DATA_BASE
) (
  input  logic                               clk,
  input  logic                               rst,
  sram_controller_if.slave                   bus,
  inout  wire  [mips_mem_pkg::SRAM_DW-1:0]   SRAM_DQ,
  output logic [mips_mem_pkg::SRAM_AW-1:0]   SRAM_ADDR,
  output logic                               SRAM_WE_N
);
  import mips_mem_pkg::*;

  localparam int            CW   = $clog2(PHASE_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(PHASE_CYCLES - 1);

  sram_state_t        state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [SRAM_AW-2:0] addr_q, addr_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [31:0]        rdata_q, rdata_d;
  logic [SRAM_AW-1:0] sram_addr_q, sram_addr_d;
  logic               we_n_q, we_n_d;
  logic [31:0]        eff;
  logic               last;
  logic               dq_oe;
  logic               unused_eff;

  assign eff        = bus.address - DATA_BASE;
  assign unused_eff = ^{eff[31:SRAM_AW+1], eff[1:0]};
  assign last       = (cnt_q == LAST);

  // Drive enable follows the registered state, so reset releases the bus at once.
  assign dq_oe   = (state_q == WR_LO) || (state_q == WR_HI);
  assign SRAM_DQ = dq_oe ? ((state_q == WR_HI) ? wdata_q[31:16] : wdata_q[15:0]) : 'z;

  assign SRAM_ADDR     = sram_addr_q;
  assign SRAM_WE_N     = we_n_q;
  assign bus.read_data = rdata_q;
  assign bus.busy      = ((state_q == IDLE) && (bus.rd_en || bus.wr_en)) ||
                         ((state_q != IDLE) && (state_q != DONE));

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    sram_addr_d = sram_addr_q;
    unique case (state_q)
      IDLE: begin
        if (bus.wr_en || bus.rd_en) begin
          state_d     = bus.wr_en ? WR_LO : RD_LO;
          cnt_d       = '0;
          addr_d      = eff[SRAM_AW:2];
          wdata_d     = bus.write_data;
          sram_addr_d = {eff[SRAM_AW:2], 1'b0};
        end
      end
      RD_LO, WR_LO: begin
        if (last) begin
          state_d     = (state_q == RD_LO) ? RD_HI : WR_HI;
          cnt_d       = '0;
          sram_addr_d = {addr_q, 1'b1};
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RD_HI, WR_HI: begin
        if (last) begin
          state_d = DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if ((state_q == RD_LO) && last) rdata_d[15:0]  = SRAM_DQ;
    if ((state_q == RD_HI) && last) rdata_d[31:16] = SRAM_DQ;
    // Strobe low for all but the last clock of a write phase, so the rising
    // edge lands while address and data are still stable.
    we_n_d = !(((state_d == WR_LO) || (state_d == WR_HI)) && (cnt_d != LAST));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      sram_addr_q <= '0;
      we_n_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      sram_addr_q <= sram_addr_d;
      we_n_q      <= we_n_d;
    end
  end
endmodule
